// File: rtl/aes_pkg.sv
// Shared AES package: block/byte types, FSM state encoding, byte-position helpers
// and the GF(2^8) arithmetic used by the iterative inverse cipher.
// State byte i sits at data[127-8i -: 8]; row = i mod 4, col = i div 4.
package aes_pkg;

   localparam int unsigned NR       = 10;
   localparam int unsigned BLOCK_W  = 128;
   localparam int unsigned NB_BYTES = 16;
   localparam int unsigned RK_IDX_W = 4;

   typedef logic [BLOCK_W-1:0]  state_t;
   typedef logic [7:0]          byte_t;
   typedef logic [RK_IDX_W-1:0] rk_idx_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUND = 2'd1,
      ST_FINAL = 2'd2,
      ST_DONE  = 2'd3
   } dec_state_e;

   localparam rk_idx_t RK_LAST  = rk_idx_t'(NR);
   localparam rk_idx_t RK_FIRST = rk_idx_t'(0);

   // Byte-position helpers
   function automatic int unsigned byte_row(int unsigned i);
      return i % 4;
   endfunction

   function automatic int unsigned byte_col(int unsigned i);
      return i / 4;
   endfunction

   function automatic int unsigned byte_pos(int unsigned row, int unsigned col);
      return (col % 4) * 4 + (row % 4);
   endfunction

   function automatic byte_t get_byte(state_t s, int unsigned i);
      return s[7'(BLOCK_W - 8 - 8 * i) +: 8];
   endfunction

   function automatic state_t set_byte(state_t s, int unsigned i, byte_t b);
      state_t o;
      o = s;
      o[7'(BLOCK_W - 8 - 8 * i) +: 8] = b;
      return o;
   endfunction

   // Multiply by x modulo 0x11b
   function automatic byte_t xtime(byte_t b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic byte_t gf_mul(byte_t a, byte_t b);
      byte_t p;
      byte_t x;
      p = 8'h00;
      x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[3'(k)]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // out[r][c] = in[r][(c-r) mod 4]
   function automatic state_t inv_shift_rows(state_t s);
      state_t      o;
      int unsigned r;
      int unsigned c;
      o = '0;
      for (int unsigned i = 0; i < NB_BYTES; i++) begin
         r = byte_row(i);
         c = byte_col(i);
         o = set_byte(o, i, get_byte(s, byte_pos(r, c + 4 - r)));
      end
      return o;
   endfunction

   function automatic state_t inv_mix_columns(state_t s);
      state_t o;
      byte_t  a0, a1, a2, a3;
      o = '0;
      for (int unsigned c = 0; c < 4; c++) begin
         a0 = get_byte(s, byte_pos(0, c));
         a1 = get_byte(s, byte_pos(1, c));
         a2 = get_byte(s, byte_pos(2, c));
         a3 = get_byte(s, byte_pos(3, c));
         o = set_byte(o, byte_pos(0, c), gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09));
         o = set_byte(o, byte_pos(1, c), gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d));
         o = set_byte(o, byte_pos(2, c), gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b));
         o = set_byte(o, byte_pos(3, c), gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e));
      end
      return o;
   endfunction

endpackage

// File: rtl/aes_dec_iter_if.sv
// Block handshake and round-key lookup bus for the iterative AES decryptor.
// slave  : the core (consumes ciphertext/round keys, produces plaintext, rk_idx)
// master : the surrounding wrapper / key store / testbench
interface aes_dec_iter_if;
   import aes_pkg::*;

   logic    in_valid;
   logic    in_ready;
   state_t  in_data;
   rk_idx_t rk_idx;
   state_t  rk_data;
   logic    out_valid;
   logic    out_ready;
   state_t  out_data;

   modport slave (
      input  in_valid, in_data, rk_data, out_ready,
      output in_ready, rk_idx, out_valid, out_data
   );

   modport master (
      output in_valid, in_data, rk_data, out_ready,
      input  in_ready, rk_idx, out_valid, out_data
   );
endinterface

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box for one byte.
// i_byte   : input byte
// o_byte_c : InvSubBytes(i_byte), combinational
module inv_sbox (
   input  logic [7:0] i_byte,
   output logic [7:0] o_byte_c
);

   always_comb begin
      o_byte_c = 8'h00;
      case (i_byte)
         8'h00: o_byte_c = 8'h52; 8'h01: o_byte_c = 8'h09; 8'h02: o_byte_c = 8'h6a; 8'h03: o_byte_c = 8'hd5; 8'h04: o_byte_c = 8'h30; 8'h05: o_byte_c = 8'h36; 8'h06: o_byte_c = 8'ha5; 8'h07: o_byte_c = 8'h38; 8'h08: o_byte_c = 8'hbf; 8'h09: o_byte_c = 8'h40; 8'h0a: o_byte_c = 8'ha3; 8'h0b: o_byte_c = 8'h9e; 8'h0c: o_byte_c = 8'h81; 8'h0d: o_byte_c = 8'hf3; 8'h0e: o_byte_c = 8'hd7; 8'h0f: o_byte_c = 8'hfb;
         8'h10: o_byte_c = 8'h7c; 8'h11: o_byte_c = 8'he3; 8'h12: o_byte_c = 8'h39; 8'h13: o_byte_c = 8'h82; 8'h14: o_byte_c = 8'h9b; 8'h15: o_byte_c = 8'h2f; 8'h16: o_byte_c = 8'hff; 8'h17: o_byte_c = 8'h87; 8'h18: o_byte_c = 8'h34; 8'h19: o_byte_c = 8'h8e; 8'h1a: o_byte_c = 8'h43; 8'h1b: o_byte_c = 8'h44; 8'h1c: o_byte_c = 8'hc4; 8'h1d: o_byte_c = 8'hde; 8'h1e: o_byte_c = 8'he9; 8'h1f: o_byte_c = 8'hcb;
         8'h20: o_byte_c = 8'h54; 8'h21: o_byte_c = 8'h7b; 8'h22: o_byte_c = 8'h94; 8'h23: o_byte_c = 8'h32; 8'h24: o_byte_c = 8'ha6; 8'h25: o_byte_c = 8'hc2; 8'h26: o_byte_c = 8'h23; 8'h27: o_byte_c = 8'h3d; 8'h28: o_byte_c = 8'hee; 8'h29: o_byte_c = 8'h4c; 8'h2a: o_byte_c = 8'h95; 8'h2b: o_byte_c = 8'h0b; 8'h2c: o_byte_c = 8'h42; 8'h2d: o_byte_c = 8'hfa; 8'h2e: o_byte_c = 8'hc3; 8'h2f: o_byte_c = 8'h4e;
         8'h30: o_byte_c = 8'h08; 8'h31: o_byte_c = 8'h2e; 8'h32: o_byte_c = 8'ha1; 8'h33: o_byte_c = 8'h66; 8'h34: o_byte_c = 8'h28; 8'h35: o_byte_c = 8'hd9; 8'h36: o_byte_c = 8'h24; 8'h37: o_byte_c = 8'hb2; 8'h38: o_byte_c = 8'h76; 8'h39: o_byte_c = 8'h5b; 8'h3a: o_byte_c = 8'ha2; 8'h3b: o_byte_c = 8'h49; 8'h3c: o_byte_c = 8'h6d; 8'h3d: o_byte_c = 8'h8b; 8'h3e: o_byte_c = 8'hd1; 8'h3f: o_byte_c = 8'h25;
         8'h40: o_byte_c = 8'h72; 8'h41: o_byte_c = 8'hf8; 8'h42: o_byte_c = 8'hf6; 8'h43: o_byte_c = 8'h64; 8'h44: o_byte_c = 8'h86; 8'h45: o_byte_c = 8'h68; 8'h46: o_byte_c = 8'h98; 8'h47: o_byte_c = 8'h16; 8'h48: o_byte_c = 8'hd4; 8'h49: o_byte_c = 8'ha4; 8'h4a: o_byte_c = 8'h5c; 8'h4b: o_byte_c = 8'hcc; 8'h4c: o_byte_c = 8'h5d; 8'h4d: o_byte_c = 8'h65; 8'h4e: o_byte_c = 8'hb6; 8'h4f: o_byte_c = 8'h92;
         8'h50: o_byte_c = 8'h6c; 8'h51: o_byte_c = 8'h70; 8'h52: o_byte_c = 8'h48; 8'h53: o_byte_c = 8'h50; 8'h54: o_byte_c = 8'hfd; 8'h55: o_byte_c = 8'hed; 8'h56: o_byte_c = 8'hb9; 8'h57: o_byte_c = 8'hda; 8'h58: o_byte_c = 8'h5e; 8'h59: o_byte_c = 8'h15; 8'h5a: o_byte_c = 8'h46; 8'h5b: o_byte_c = 8'h57; 8'h5c: o_byte_c = 8'ha7; 8'h5d: o_byte_c = 8'h8d; 8'h5e: o_byte_c = 8'h9d; 8'h5f: o_byte_c = 8'h84;
         8'h60: o_byte_c = 8'h90; 8'h61: o_byte_c = 8'hd8; 8'h62: o_byte_c = 8'hab; 8'h63: o_byte_c = 8'h00; 8'h64: o_byte_c = 8'h8c; 8'h65: o_byte_c = 8'hbc; 8'h66: o_byte_c = 8'hd3; 8'h67: o_byte_c = 8'h0a; 8'h68: o_byte_c = 8'hf7; 8'h69: o_byte_c = 8'he4; 8'h6a: o_byte_c = 8'h58; 8'h6b: o_byte_c = 8'h05; 8'h6c: o_byte_c = 8'hb8; 8'h6d: o_byte_c = 8'hb3; 8'h6e: o_byte_c = 8'h45; 8'h6f: o_byte_c = 8'h06;
         8'h70: o_byte_c = 8'hd0; 8'h71: o_byte_c = 8'h2c; 8'h72: o_byte_c = 8'h1e; 8'h73: o_byte_c = 8'h8f; 8'h74: o_byte_c = 8'hca; 8'h75: o_byte_c = 8'h3f; 8'h76: o_byte_c = 8'h0f; 8'h77: o_byte_c = 8'h02; 8'h78: o_byte_c = 8'hc1; 8'h79: o_byte_c = 8'haf; 8'h7a: o_byte_c = 8'hbd; 8'h7b: o_byte_c = 8'h03; 8'h7c: o_byte_c = 8'h01; 8'h7d: o_byte_c = 8'h13; 8'h7e: o_byte_c = 8'h8a; 8'h7f: o_byte_c = 8'h6b;
         8'h80: o_byte_c = 8'h3a; 8'h81: o_byte_c = 8'h91; 8'h82: o_byte_c = 8'h11; 8'h83: o_byte_c = 8'h41; 8'h84: o_byte_c = 8'h4f; 8'h85: o_byte_c = 8'h67; 8'h86: o_byte_c = 8'hdc; 8'h87: o_byte_c = 8'hea; 8'h88: o_byte_c = 8'h97; 8'h89: o_byte_c = 8'hf2; 8'h8a: o_byte_c = 8'hcf; 8'h8b: o_byte_c = 8'hce; 8'h8c: o_byte_c = 8'hf0; 8'h8d: o_byte_c = 8'hb4; 8'h8e: o_byte_c = 8'he6; 8'h8f: o_byte_c = 8'h73;
         8'h90: o_byte_c = 8'h96; 8'h91: o_byte_c = 8'hac; 8'h92: o_byte_c = 8'h74; 8'h93: o_byte_c = 8'h22; 8'h94: o_byte_c = 8'he7; 8'h95: o_byte_c = 8'had; 8'h96: o_byte_c = 8'h35; 8'h97: o_byte_c = 8'h85; 8'h98: o_byte_c = 8'he2; 8'h99: o_byte_c = 8'hf9; 8'h9a: o_byte_c = 8'h37; 8'h9b: o_byte_c = 8'he8; 8'h9c: o_byte_c = 8'h1c; 8'h9d: o_byte_c = 8'h75; 8'h9e: o_byte_c = 8'hdf; 8'h9f: o_byte_c = 8'h6e;
         8'ha0: o_byte_c = 8'h47; 8'ha1: o_byte_c = 8'hf1; 8'ha2: o_byte_c = 8'h1a; 8'ha3: o_byte_c = 8'h71; 8'ha4: o_byte_c = 8'h1d; 8'ha5: o_byte_c = 8'h29; 8'ha6: o_byte_c = 8'hc5; 8'ha7: o_byte_c = 8'h89; 8'ha8: o_byte_c = 8'h6f; 8'ha9: o_byte_c = 8'hb7; 8'haa: o_byte_c = 8'h62; 8'hab: o_byte_c = 8'h0e; 8'hac: o_byte_c = 8'haa; 8'had: o_byte_c = 8'h18; 8'hae: o_byte_c = 8'hbe; 8'haf: o_byte_c = 8'h1b;
         8'hb0: o_byte_c = 8'hfc; 8'hb1: o_byte_c = 8'h56; 8'hb2: o_byte_c = 8'h3e; 8'hb3: o_byte_c = 8'h4b; 8'hb4: o_byte_c = 8'hc6; 8'hb5: o_byte_c = 8'hd2; 8'hb6: o_byte_c = 8'h79; 8'hb7: o_byte_c = 8'h20; 8'hb8: o_byte_c = 8'h9a; 8'hb9: o_byte_c = 8'hdb; 8'hba: o_byte_c = 8'hc0; 8'hbb: o_byte_c = 8'hfe; 8'hbc: o_byte_c = 8'h78; 8'hbd: o_byte_c = 8'hcd; 8'hbe: o_byte_c = 8'h5a; 8'hbf: o_byte_c = 8'hf4;
         8'hc0: o_byte_c = 8'h1f; 8'hc1: o_byte_c = 8'hdd; 8'hc2: o_byte_c = 8'ha8; 8'hc3: o_byte_c = 8'h33; 8'hc4: o_byte_c = 8'h88; 8'hc5: o_byte_c = 8'h07; 8'hc6: o_byte_c = 8'hc7; 8'hc7: o_byte_c = 8'h31; 8'hc8: o_byte_c = 8'hb1; 8'hc9: o_byte_c = 8'h12; 8'hca: o_byte_c = 8'h10; 8'hcb: o_byte_c = 8'h59; 8'hcc: o_byte_c = 8'h27; 8'hcd: o_byte_c = 8'h80; 8'hce: o_byte_c = 8'hec; 8'hcf: o_byte_c = 8'h5f;
         8'hd0: o_byte_c = 8'h60; 8'hd1: o_byte_c = 8'h51; 8'hd2: o_byte_c = 8'h7f; 8'hd3: o_byte_c = 8'ha9; 8'hd4: o_byte_c = 8'h19; 8'hd5: o_byte_c = 8'hb5; 8'hd6: o_byte_c = 8'h4a; 8'hd7: o_byte_c = 8'h0d; 8'hd8: o_byte_c = 8'h2d; 8'hd9: o_byte_c = 8'he5; 8'hda: o_byte_c = 8'h7a; 8'hdb: o_byte_c = 8'h9f; 8'hdc: o_byte_c = 8'h93; 8'hdd: o_byte_c = 8'hc9; 8'hde: o_byte_c = 8'h9c; 8'hdf: o_byte_c = 8'hef;
         8'he0: o_byte_c = 8'ha0; 8'he1: o_byte_c = 8'he0; 8'he2: o_byte_c = 8'h3b; 8'he3: o_byte_c = 8'h4d; 8'he4: o_byte_c = 8'hae; 8'he5: o_byte_c = 8'h2a; 8'he6: o_byte_c = 8'hf5; 8'he7: o_byte_c = 8'hb0; 8'he8: o_byte_c = 8'hc8; 8'he9: o_byte_c = 8'heb; 8'hea: o_byte_c = 8'hbb; 8'heb: o_byte_c = 8'h3c; 8'hec: o_byte_c = 8'h83; 8'hed: o_byte_c = 8'h53; 8'hee: o_byte_c = 8'h99; 8'hef: o_byte_c = 8'h61;
         8'hf0: o_byte_c = 8'h17; 8'hf1: o_byte_c = 8'h2b; 8'hf2: o_byte_c = 8'h04; 8'hf3: o_byte_c = 8'h7e; 8'hf4: o_byte_c = 8'hba; 8'hf5: o_byte_c = 8'h77; 8'hf6: o_byte_c = 8'hd6; 8'hf7: o_byte_c = 8'h26; 8'hf8: o_byte_c = 8'he1; 8'hf9: o_byte_c = 8'h69; 8'hfa: o_byte_c = 8'h14; 8'hfb: o_byte_c = 8'h63; 8'hfc: o_byte_c = 8'h55; 8'hfd: o_byte_c = 8'h21; 8'hfe: o_byte_c = 8'h0c; 8'hff: o_byte_c = 8'h7d;
         default: o_byte_c = 8'h00;
      endcase
   end

endmodule

// File: rtl/aes_dec_iter.sv
// Iterative AES-128 decryption core: one inverse-cipher round per clock using
// round keys fetched by index from an external key-schedule store.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   i_abort    : drop the block in flight (only with AES_DEC_ABORT_EN defined)
//   io_bus     : aes_dec_iter_if.slave - ciphertext in, rk_idx/rk_data lookup,
//                plaintext out with valid/ready
// Build option: AES_DEC_ABORT_EN adds i_abort; undefined, every accepted block
// runs to completion.
module aes_dec_iter
   import aes_pkg::*;
(
   input logic           clk,
   input logic           rst_n,
`ifdef AES_DEC_ABORT_EN
   input logic           i_abort,
`endif
   aes_dec_iter_if.slave io_bus
);

   dec_state_e r_state, w_state_nxt;
   rk_idx_t    r_rnd, w_rnd_nxt;
   rk_idx_t    r_rk_idx, w_rk_idx_nxt;
   state_t     r_st, w_st_nxt;
   logic       r_out_valid, w_out_valid_nxt;
   state_t     r_out_data, w_out_data_nxt;

   state_t w_isr;
   state_t w_isb;
   state_t w_ark;
   state_t w_round;

   // Round datapath: InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns
   assign w_isr = inv_shift_rows(r_st);

   for (genvar g = 0; g < NB_BYTES; g++) begin : g_isb
      inv_sbox u_inv_sbox (
         .i_byte   (w_isr[BLOCK_W - 8 - 8 * g +: 8]),
         .o_byte_c (w_isb[BLOCK_W - 8 - 8 * g +: 8])
      );
   end

   assign w_ark   = w_isb ^ io_bus.rk_data;
   assign w_round = inv_mix_columns(w_ark);

   // in_ready is gated by rst_n so it is low for the whole reset window
   assign io_bus.in_ready  = rst_n & (r_state == ST_IDLE);
   assign io_bus.rk_idx    = r_rk_idx;
   assign io_bus.out_valid = r_out_valid;
   assign io_bus.out_data  = r_out_data;

   // State, round counter and datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_rnd       <= '0;
         r_rk_idx    <= RK_LAST;
         r_st        <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_rnd       <= w_rnd_nxt;
         r_rk_idx    <= w_rk_idx_nxt;
         r_st        <= w_st_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_out_data  <= w_out_data_nxt;
      end
   end

   // Next-state / next-output logic; rk_idx is registered ahead of the state it serves
   always_comb begin
      w_state_nxt     = r_state;
      w_rnd_nxt       = r_rnd;
      w_rk_idx_nxt    = r_rk_idx;
      w_st_nxt        = r_st;
      w_out_valid_nxt = r_out_valid;
      w_out_data_nxt  = r_out_data;

      case (r_state)
         ST_IDLE: begin
            w_rk_idx_nxt = RK_LAST;
            if (io_bus.in_valid) begin
               w_st_nxt     = io_bus.in_data ^ io_bus.rk_data;
               w_rnd_nxt    = rk_idx_t'(NR - 1);
               w_rk_idx_nxt = rk_idx_t'(NR - 1);
               w_state_nxt  = ST_ROUND;
            end
         end
         ST_ROUND: begin
            w_st_nxt  = w_round;
            w_rnd_nxt = r_rnd - rk_idx_t'(1);
            if (r_rnd == rk_idx_t'(1)) begin
               w_state_nxt  = ST_FINAL;
               w_rk_idx_nxt = RK_FIRST;
            end else begin
               w_rk_idx_nxt = r_rnd - rk_idx_t'(1);
            end
         end
         ST_FINAL: begin
            w_st_nxt        = w_ark;
            w_out_data_nxt  = w_ark;
            w_out_valid_nxt = 1'b1;
            w_rk_idx_nxt    = RK_LAST;
            w_state_nxt     = ST_DONE;
         end
         ST_DONE: begin
            w_rk_idx_nxt = RK_LAST;
            if (io_bus.out_ready) begin
               w_out_valid_nxt = 1'b0;
               w_state_nxt     = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt     = ST_IDLE;
            w_rk_idx_nxt    = RK_LAST;
            w_out_valid_nxt = 1'b0;
         end
      endcase

`ifdef AES_DEC_ABORT_EN
      // Abort only affects a block still being computed
      if (i_abort && (r_state == ST_ROUND || r_state == ST_FINAL)) begin
         w_state_nxt     = ST_IDLE;
         w_rnd_nxt       = '0;
         w_rk_idx_nxt    = RK_LAST;
         w_st_nxt        = '0;
         w_out_valid_nxt = 1'b0;
         w_out_data_nxt  = r_out_data;
      end
`endif
   end

endmodule

// File: tb/tb_aes_dec_iter.sv
// Testbench for aes_dec_iter: forward AES-128 reference (S-box derived from
// GF(2^8) inverse + affine map, key expansion, encryption) produces ciphertext
// for the DUT to decrypt; the original plaintext is the expected result.
module tb_aes_dec_iter;

   typedef logic [0:15][7:0] blk_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   aes_dec_iter_if bus ();

`ifdef AES_DEC_ABORT_EN
   logic abort = 1'b0;
`endif

   aes_dec_iter dut (
      .clk     (clk),
      .rst_n   (rst_n),
`ifdef AES_DEC_ABORT_EN
      .i_abort (abort),
`endif
      .io_bus  (bus)
   );

   logic [7:0]   sbox_tab [0:255];
   logic [127:0] rk_tab   [0:15];

   // Key store: combinational lookup by the index the core requests
   assign bus.rk_data = rk_tab[bus.rk_idx];

   int n_cmp = 0;
   int n_bad = 0;

   localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] RK10_C1 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // ---------------- reference model ----------------
   function automatic logic [7:0] xt(logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] mul(logic [7:0] a, logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      logic [7:0] y;
      p = 8'h00;
      x = a;
      y = b;
      while (y != 8'h00) begin
         if (y[0]) p = p ^ x;
         x = xt(x);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(logic [7:0] x, int n);
      logic [7:0] r;
      r = x;
      for (int k = 0; k < n; k++) r = {r[6:0], r[7]};
      return r;
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int a = 0; a < 256; a++) begin
         inv = 8'h00;
         for (int b = 1; b < 256; b++)
            if (mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         sbox_tab[8'(a)] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      end
   endtask

   task automatic expand_key(input logic [127:0] key);
      logic [31:0]      w [0:43];
      logic [0:3][31:0] kw;
      logic [31:0]      t;
      logic [7:0]       rcon;
      kw   = key;
      rcon = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = kw[2'(i)];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
            t = t ^ {rcon, 24'h000000};
            rcon = xt(rcon);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 16; r++) rk_tab[r] = '0;
      for (int r = 0; r <= 10; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   function automatic blk_t sub_bytes(blk_t s);
      blk_t o;
      for (int i = 0; i < 16; i++) o[4'(i)] = sbox_tab[s[4'(i)]];
      return o;
   endfunction

   // Row r of column c takes the byte from column (c + r) mod 4
   function automatic blk_t shift_rows(blk_t s);
      blk_t o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[4'(c * 4 + r)] = s[4'(((c + r) % 4) * 4 + r)];
      return o;
   endfunction

   function automatic blk_t mix_cols(blk_t s);
      blk_t       o;
      logic [7:0] a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[4'(c*4)];  a1 = s[4'(c*4+1)];  a2 = s[4'(c*4+2)];  a3 = s[4'(c*4+3)];
         o[4'(c*4)]   = mul(a0, 8'h02) ^ mul(a1, 8'h03) ^ a2 ^ a3;
         o[4'(c*4+1)] = a0 ^ mul(a1, 8'h02) ^ mul(a2, 8'h03) ^ a3;
         o[4'(c*4+2)] = a0 ^ a1 ^ mul(a2, 8'h02) ^ mul(a3, 8'h03);
         o[4'(c*4+3)] = mul(a0, 8'h03) ^ a1 ^ a2 ^ mul(a3, 8'h02);
      end
      return o;
   endfunction

   function automatic logic [127:0] encrypt(logic [127:0] pt);
      blk_t s;
      s = pt ^ rk_tab[0];
      for (int r = 1; r < 10; r++) s = mix_cols(shift_rows(sub_bytes(s))) ^ rk_tab[r];
      s = shift_rows(sub_bytes(s)) ^ rk_tab[10];
      return s;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      while (!bus.in_ready && n < 60) begin
         tick();
         n++;
      end
      if (!bus.in_ready) check({tag, "_ready_timeout"}, 128'(bus.in_ready), 128'(1));
   endtask

   // Accept one block and wait for its result; trace checks rk_idx per cycle and latency
   task automatic run_block(input logic [127:0] ct, input logic [127:0] exp, input bit trace, input string tag);
      int n;
      wait_ready(tag);
      if (trace) check({tag, "_rk_idle"}, 128'(bus.rk_idx), 128'(10));
      bus.in_valid = 1'b1;
      bus.in_data  = ct;
      tick();
      bus.in_valid = 1'b0;
      bus.in_data  = rnd128();
      n = 0;
      while (!bus.out_valid && n < 40) begin
         if (trace) check({tag, "_rk_seq"}, 128'(bus.rk_idx), 128'(9 - n));
         tick();
         n++;
      end
      if (trace) check({tag, "_latency"}, 128'(n), 128'(10));
      if (bus.out_valid) check({tag, "_data"}, bus.out_data, exp);
      else check({tag, "_out_timeout"}, 128'(bus.out_valid), 128'(1));
   endtask

   initial begin
      int   stamps [0:2];
      int   n_out;
      int   t;
      logic bp_stable, bp_rdy_low, bp_vld_high;
      logic [127:0] key, pt;

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      for (int r = 0; r < 16; r++) rk_tab[r] = '0;
      build_sbox();

      // Reference model sanity on the C.1 vector
      expand_key(KEY_C1);
      check("model_rk10", rk_tab[10], RK10_C1);
      check("model_ct", encrypt(PT_C1), CT_C1);

      // Reset state
      rst_n = 1'b0;
      repeat (3) tick();
      check("rst_out_valid", 128'(bus.out_valid), 128'(0));
      check("rst_out_data", bus.out_data, 128'(0));
      check("rst_in_ready", 128'(bus.in_ready), 128'(0));
      check("rst_rk_idx", 128'(bus.rk_idx), 128'(10));
      rst_n = 1'b1;
      #1;
      check("rst_rel_in_ready", 128'(bus.in_ready), 128'(1));

      // C.1 with rk_idx trace and latency
      bus.out_ready = 1'b1;
      run_block(CT_C1, PT_C1, 1'b1, "c1");
      tick();
      check("c1_back_idle", 128'(bus.in_ready), 128'(1));

      // Back-pressure in DONE
      bus.out_ready = 1'b0;
      run_block(CT_C1, PT_C1, 1'b0, "bp");
      bp_stable   = 1'b1;
      bp_rdy_low  = 1'b1;
      bp_vld_high = 1'b1;
      for (int i = 0; i < 20; i++) begin
         bus.in_valid = 1'($urandom_range(0, 1));
         bus.in_data  = rnd128();
         tick();
         if (bus.out_data !== PT_C1) bp_stable = 1'b0;
         if (bus.in_ready !== 1'b0) bp_rdy_low = 1'b0;
         if (bus.out_valid !== 1'b1) bp_vld_high = 1'b0;
      end
      bus.in_valid = 1'b0;
      check("bp_data_stable", 128'(bp_stable), 128'(1));
      check("bp_in_ready_low", 128'(bp_rdy_low), 128'(1));
      check("bp_valid_held", 128'(bp_vld_high), 128'(1));
      bus.out_ready = 1'b1;
      tick();
      check("bp_release_ready", 128'(bus.in_ready), 128'(1));
      check("bp_release_valid", 128'(bus.out_valid), 128'(0));
      check("bp_release_rk", 128'(bus.rk_idx), 128'(10));

      // Back-to-back with out_ready tied high
      wait_ready("b2b");
      bus.in_valid = 1'b1;
      bus.in_data  = CT_C1;
      n_out = 0;
      t = 0;
      for (int i = 0; i < 3; i++) stamps[i] = 0;
      while (n_out < 3 && t < 60) begin
         tick();
         t++;
         if (bus.out_valid) begin
            stamps[n_out] = t;
            check("b2b_data", bus.out_data, PT_C1);
            n_out++;
         end
      end
      bus.in_valid = 1'b0;
      check("b2b_count", 128'(n_out), 128'(3));
      check("b2b_gap1", 128'(stamps[1] - stamps[0]), 128'(12));
      check("b2b_gap2", 128'(stamps[2] - stamps[1]), 128'(12));

      // Reset in the middle of a block (ROUND with rnd = 5)
      wait_ready("rstmid");
      bus.in_valid = 1'b1;
      bus.in_data  = CT_C1;
      tick();
      bus.in_valid = 1'b0;
      t = 0;
      while (bus.rk_idx != 4'd5 && t < 20) begin
         tick();
         t++;
      end
      check("rstmid_reach_rnd5", 128'(bus.rk_idx), 128'(5));
      rst_n = 1'b0;
      tick();
      check("rstmid_out_valid", 128'(bus.out_valid), 128'(0));
      check("rstmid_out_data", bus.out_data, 128'(0));
      check("rstmid_in_ready", 128'(bus.in_ready), 128'(0));
      rst_n = 1'b1;
      run_block(CT_C1, PT_C1, 1'b0, "rstmid_next");

`ifdef AES_DEC_ABORT_EN
      // Abort in FINAL
      wait_ready("abort");
      bus.in_valid = 1'b1;
      bus.in_data  = CT_C1;
      tick();
      bus.in_valid = 1'b0;
      t = 0;
      while (bus.rk_idx != 4'd0 && t < 20) begin
         tick();
         t++;
      end
      check("abort_reach_final", 128'(bus.rk_idx), 128'(0));
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_in_ready", 128'(bus.in_ready), 128'(1));
      check("abort_out_valid", 128'(bus.out_valid), 128'(0));
      tick();
      check("abort_no_valid_later", 128'(bus.out_valid), 128'(0));
      run_block(CT_C1, PT_C1, 1'b0, "abort_next");
`endif

      // Random key/plaintext pairs
      for (int i = 0; i < 1000; i++) begin
         key = rnd128();
         pt  = rnd128();
         expand_key(key);
         run_block(encrypt(pt), pt, 1'b0, "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
